// File: rtl/butterfly_r2_pipe_if.sv
// butterfly_r2_pipe_if: sample-pair stream in, butterfly result stream out
interface butterfly_r2_pipe_if #(parameter int N = 16);
  logic in_valid, in_ready, in_last, inv;
  logic signed [N-1:0] in0_r, in0_i, in1_r, in1_i, twiddle_r, twiddle_i;
  logic out_valid, out_ready, out_last, out_ovf;
  logic signed [N-1:0] out0_r, out0_i, out1_r, out1_i;
  modport slave (
    input in_valid, in_last, inv, in0_r, in0_i, in1_r, in1_i, twiddle_r, twiddle_i, out_ready,
    output in_ready, out_valid, out_last, out_ovf, out0_r, out0_i, out1_r, out1_i
  );
  modport master (
    output in_valid, in_last, inv, in0_r, in0_i, in1_r, in1_i, twiddle_r, twiddle_i, out_ready,
    input in_ready, out_valid, out_last, out_ovf, out0_r, out0_i, out1_r, out1_i
  );
endinterface

// File: rtl/butterfly_r2_pipe.sv
// butterfly_r2_pipe: 3-stage radix-2 DIT butterfly a +/- w*b with valid/ready, conjugate mode, scaling and saturation
module butterfly_r2_pipe #(
  parameter int N = 16,
  parameter int Q = 14,
  parameter int SCALE = 0,
  parameter int SAT = 1
) (
  input logic clk,
  input logic rst,
  butterfly_r2_pipe_if.slave bus
);
  localparam int P = 2 * N;
  localparam int W = 2 * N + 1 - Q;
  localparam int S = W + 1;
  logic w_en, w_ovf;
  logic signed [P-1:0] w_rr, w_ii, w_ri, w_ir, r_rr, r_ii, r_ri, r_ir;
  logic signed [P:0] w_pr, w_pi;
  logic signed [N-1:0] r1_ar, r1_ai, r2_ar, r2_ai;
  logic signed [W-1:0] r2_wr, r2_wi;
  logic r1_v, r1_inv, r1_last, r2_v, r2_last, r_v, r_last, r_ovf;
  logic signed [S-1:0] w_s [4];
  logic [N:0] w_f [4];
  logic [N-1:0] r_o [4];
  function automatic logic [N:0] fit(input logic signed [S-1:0] v);
    logic o;
    o = ~(&v[S-1:N-1]) & |v[S-1:N-1];
    fit = {o, (o && SAT != 0) ? {v[S-1], {(N-1){~v[S-1]}}} : v[N-1:0]};
  endfunction
  assign w_en = ~(r_v & ~bus.out_ready);
  assign bus.in_ready = w_en;
  assign w_rr = P'(bus.in1_r) * P'(bus.twiddle_r);
  assign w_ii = P'(bus.in1_i) * P'(bus.twiddle_i);
  assign w_ri = P'(bus.in1_r) * P'(bus.twiddle_i);
  assign w_ir = P'(bus.in1_i) * P'(bus.twiddle_r);
  assign w_pr = r1_inv ? (P+1)'(r_rr) + (P+1)'(r_ii) : (P+1)'(r_rr) - (P+1)'(r_ii);
  assign w_pi = r1_inv ? (P+1)'(r_ir) - (P+1)'(r_ri) : (P+1)'(r_ri) + (P+1)'(r_ir);
  always_comb begin
    w_s[0] = S'(r2_ar) + S'(r2_wr);
    w_s[1] = S'(r2_ai) + S'(r2_wi);
    w_s[2] = S'(r2_ar) - S'(r2_wr);
    w_s[3] = S'(r2_ai) - S'(r2_wi);
    for (int k = 0; k < 4; k++) w_f[k] = fit(SCALE != 0 ? w_s[k] >>> 1 : w_s[k]);
  end
  assign w_ovf = w_f[0][N] | w_f[1][N] | w_f[2][N] | w_f[3][N];
  always_ff @(posedge clk) begin
    if (!rst) begin
      {r1_v, r1_inv, r1_last, r2_v, r2_last, r_v, r_last, r_ovf} <= '0;
      {r_rr, r_ii, r_ri, r_ir} <= '0;
      {r1_ar, r1_ai, r2_ar, r2_ai, r2_wr, r2_wi} <= '0;
      for (int k = 0; k < 4; k++) r_o[k] <= '0;
    end else if (w_en) begin
      r1_v <= bus.in_valid;
      r1_inv <= bus.inv;
      r1_last <= bus.in_last;
      r1_ar <= bus.in0_r;
      r1_ai <= bus.in0_i;
      {r_rr, r_ii, r_ri, r_ir} <= {w_rr, w_ii, w_ri, w_ir};
      r2_v <= r1_v;
      r2_last <= r1_last;
      r2_ar <= r1_ar;
      r2_ai <= r1_ai;
      r2_wr <= W'(w_pr >>> Q);
      r2_wi <= W'(w_pi >>> Q);
      r_v <= r2_v;
      r_last <= r2_v & r2_last;
      r_ovf <= r2_v & w_ovf;
      for (int k = 0; k < 4; k++) r_o[k] <= w_f[k][N-1:0];
    end
  end
  assign bus.out_valid = r_v;
  assign bus.out_last = r_last;
  assign bus.out_ovf = r_ovf;
  assign bus.out0_r = r_o[0];
  assign bus.out0_i = r_o[1];
  assign bus.out1_r = r_o[2];
  assign bus.out1_i = r_o[3];
endmodule

// File: tb/tb_butterfly_r2_pipe.sv
// tb_butterfly_r2_pipe: directed checks of the butterfly across scale/saturation variants
module tb_butterfly_r2_pipe;
  localparam int N = 16;
  logic clk = 0, rst = 0, in_valid = 0, in_last = 0, inv = 0, out_ready = 1;
  logic signed [N-1:0] ar = 0, ai = 0, br = 0, bi = 0, wr = 0, wi = 0;
  int n_chk = 0, n_fail = 0, sent = 0, rcv = 0, stalls = 0;
  always #5 clk = ~clk;
  butterfly_r2_pipe_if #(.N(N)) b0 (), b1 (), b2 ();
  assign {b0.in_valid, b0.in_last, b0.inv, b0.in0_r, b0.in0_i, b0.in1_r, b0.in1_i, b0.twiddle_r, b0.twiddle_i, b0.out_ready} = {in_valid, in_last, inv, ar, ai, br, bi, wr, wi, out_ready};
  assign {b1.in_valid, b1.in_last, b1.inv, b1.in0_r, b1.in0_i, b1.in1_r, b1.in1_i, b1.twiddle_r, b1.twiddle_i, b1.out_ready} = {in_valid, in_last, inv, ar, ai, br, bi, wr, wi, out_ready};
  assign {b2.in_valid, b2.in_last, b2.inv, b2.in0_r, b2.in0_i, b2.in1_r, b2.in1_i, b2.twiddle_r, b2.twiddle_i, b2.out_ready} = {in_valid, in_last, inv, ar, ai, br, bi, wr, wi, out_ready};
  butterfly_r2_pipe #(.N(N), .Q(14), .SCALE(0), .SAT(1)) dut (.clk(clk), .rst(rst), .bus(b0));
  butterfly_r2_pipe #(.N(N), .Q(14), .SCALE(1), .SAT(1)) dut_s (.clk(clk), .rst(rst), .bus(b1));
  butterfly_r2_pipe #(.N(N), .Q(14), .SCALE(0), .SAT(0)) dut_w (.clk(clk), .rst(rst), .bus(b2));
  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic set(input logic v, input int a_r, a_i, b_r, b_i, w_r, w_i, input logic iv, lst);
    in_valid = v;
    ar = N'(a_r);
    ai = N'(a_i);
    br = N'(b_r);
    bi = N'(b_i);
    wr = N'(w_r);
    wi = N'(w_i);
    inv = iv;
    in_last = lst;
  endtask
  task automatic one(input string tag, input int a_r, a_i, b_r, b_i, w_r, w_i, input logic iv);
    set(1, a_r, a_i, b_r, b_i, w_r, w_i, iv, 0);
    @(negedge clk);
    set(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk({tag, ".lat"}, b0.out_valid, 0);
    @(negedge clk);
    chk({tag, ".valid"}, b0.out_valid, 1);
  endtask
  initial begin
    set(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("rst.valid", b0.out_valid, 0);
    chk("rst.out0_r", b0.out0_r, 0);
    chk("rst.last", b0.out_last, 0);
    chk("rst.ovf", b0.out_ovf, 0);
    chk("rst.in_ready", b0.in_ready, 1);
    rst = 1;
    @(negedge clk);
    one("unity", 1000, 2000, 300, -400, 16384, 0, 0);
    chk("unity.out0_r", b0.out0_r, 1300);
    chk("unity.out0_i", b0.out0_i, 1600);
    chk("unity.out1_r", b0.out1_r, 700);
    chk("unity.out1_i", b0.out1_i, 2400);
    chk("unity.ovf", b0.out_ovf, 0);
    one("mj", 1000, 2000, 300, -400, 0, -16384, 0);
    chk("mj.out0_r", b0.out0_r, 600);
    chk("mj.out0_i", b0.out0_i, 1700);
    chk("mj.out1_r", b0.out1_r, 1400);
    chk("mj.out1_i", b0.out1_i, 2300);
    one("mj_inv", 1000, 2000, 300, -400, 0, -16384, 1);
    chk("mj_inv.out0_r", b0.out0_r, 1400);
    chk("mj_inv.out0_i", b0.out0_i, 2300);
    chk("mj_inv.out1_r", b0.out1_r, 600);
    chk("mj_inv.out1_i", b0.out1_i, 1700);
    one("ovf", 30000, 0, 10000, 0, 16384, 0, 0);
    chk("ovf.sat.out0_r", b0.out0_r, 32767);
    chk("ovf.sat.out1_r", b0.out1_r, 20000);
    chk("ovf.sat.out0_i", b0.out0_i, 0);
    chk("ovf.sat.ovf", b0.out_ovf, 1);
    chk("ovf.scale.out0_r", b1.out0_r, 20000);
    chk("ovf.scale.out1_r", b1.out1_r, 10000);
    chk("ovf.scale.ovf", b1.out_ovf, 0);
    chk("ovf.wrap.out0_r", b2.out0_r, -25536);
    chk("ovf.wrap.ovf", b2.out_ovf, 1);
    one("floor", 0, 0, -1, 0, 8192, 0, 0);
    chk("floor.out0_r", b0.out0_r, -1);
    chk("floor.out1_r", b0.out1_r, 1);
    chk("floor.ovf", b0.out_ovf, 0);
    chk("floor.scale.out0_r", b1.out0_r, -1);
    chk("floor.scale.out1_r", b1.out1_r, 0);
    one("wrap", 32767, 0, 1, 0, 16384, 0, 0);
    chk("wrap.out0_r", b2.out0_r, -32768);
    chk("wrap.ovf", b2.out_ovf, 1);
    chk("wrap.sat.out0_r", b0.out0_r, 32767);
    chk("wrap.sat.out1_r", b0.out1_r, 32766);
    chk("wrap.sat.ovf", b0.out_ovf, 1);
    one("edge", 32766, 0, 1, 0, 16384, 0, 0);
    chk("edge.out0_r", b0.out0_r, 32767);
    chk("edge.ovf", b0.out_ovf, 0);
    chk("edge.scale.out0_r", b1.out0_r, 16383);
    chk("edge.scale.out1_r", b1.out1_r, 16382);
    @(negedge clk);
    chk("flush.valid", b0.out_valid, 0);
    for (int c = 0; c < 30; c++) begin
      out_ready = !(c >= 6 && c < 10);
      if (sent < 8) set(1, 10 * (sent + 1), sent + 1, sent + 1, 0, 16384, 0, 0, sent == 7);
      else set(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("bp.in_ready", b0.in_ready, (c >= 6 && c < 10) ? 0 : 1);
      if (!b0.in_ready) stalls++;
      if (b0.out_valid) begin
        chk("bp.out0_r", b0.out0_r, 11 * (rcv + 1));
        chk("bp.out0_i", b0.out0_i, rcv + 1);
        chk("bp.out1_r", b0.out1_r, 9 * (rcv + 1));
        if (out_ready) begin
          chk("bp.last", b0.out_last, rcv == 7);
          rcv++;
        end
      end else chk("bp.idle_last", b0.out_last, 0);
      if (in_valid && b0.in_ready) sent++;
      @(negedge clk);
    end
    chk("bp.stalls", stalls, 4);
    chk("bp.sent", sent, 8);
    chk("bp.rcv", rcv, 8);
    out_ready = 1;
    set(1, 1, 1, 1, 1, 16384, 0, 0, 0);
    @(negedge clk);
    set(1, 2, 2, 2, 2, 16384, 0, 0, 0);
    @(negedge clk);
    set(1, 3, 3, 3, 3, 16384, 0, 0, 1);
    @(negedge clk);
    chk("rst_mid.pre_valid", b0.out_valid, 1);
    set(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 0;
    @(negedge clk);
    chk("rst_mid.valid", b0.out_valid, 0);
    chk("rst_mid.out0_r", b0.out0_r, 0);
    chk("rst_mid.out0_i", b0.out0_i, 0);
    chk("rst_mid.out1_r", b0.out1_r, 0);
    chk("rst_mid.out1_i", b0.out1_i, 0);
    chk("rst_mid.last", b0.out_last, 0);
    chk("rst_mid.ovf", b0.out_ovf, 0);
    rst = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rst_mid.stale", b0.out_valid, 0);
    end
    one("post", 5, 6, 7, 8, 16384, 0, 0);
    chk("post.out0_r", b0.out0_r, 12);
    chk("post.out0_i", b0.out0_i, 14);
    chk("post.out1_r", b0.out1_r, -2);
    chk("post.out1_i", b0.out1_i, -2);
    chk("post.last", b0.out_last, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
